lppm_frame_decoder: RTL and testbench

//  Parametrised L-PPM receive decoder (L = 2^BPS), generalising the fixed 4-PPM decoder.

---
 rtl/lppm_frame_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_lppm_frame_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lppm_frame_decoder.sv
// lppm_frame_decoder
// L-PPM receive decoder with L = 2^BPS. It oversamples din at OSR clocks per chip and
// resyncs the chip phase on falling edges. It matches SOF, slices 2M-chip symbols into
// bytes MSB first, and ends a frame on EOF. Illegal symbols and over-length frames
// raise err.
// Optional build macro: PPM_DEC_MAJORITY_EN. When defined, each chip is a 2-of-3
// majority of the samples at phases OSR/2-1, OSR/2 and OSR/2+1. This adds one cycle
// of decision latency.
module lppm_frame_decoder #(
  parameter int                 OSR       = 16,
  parameter int                 BPS       = 2,
  parameter int                 SOF_LEN   = 8,
  parameter logic [SOF_LEN-1:0] SOF_PAT   = 8'b01111011,
  parameter int                 EOF_LEN   = 4,
  parameter logic [EOF_LEN-1:0] EOF_PAT   = 4'b1101,
  parameter int                 MAX_BYTES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din,
  output logic [7:0]                     dout,
  output logic                           d_en,
  output logic                           f_en,
  output logic                           f_end,
  output logic                           err,
  output logic [$clog2(MAX_BYTES+1)-1:0] frame_len,
  output logic                           busy
);
  localparam int LEN_W = $clog2(MAX_BYTES+1);
  localparam int M     = 1 << BPS;
  localparam int SYM_N = 2 * M;
  localparam int SPB   = 8 / BPS;
  localparam int PH_W  = $clog2(OSR);
  localparam int SC_W  = $clog2(SYM_N);
  localparam int CC_W  = $clog2(SOF_LEN);
  localparam int NB_W  = $clog2(SPB);
`ifdef PPM_DEC_MAJORITY_EN
  localparam int DEC_PH = OSR/2 + 1;
`else
  localparam int DEC_PH = OSR/2;
`endif

  typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;
  state_t state, state_nx;

  logic [1:0]       sync;
  logic             fall, chip_val, chip_tick;
  logic [PH_W-1:0]  phase;
  logic [CC_W-1:0]  chip_ctr;
  logic [SOF_LEN-2:0] sof_sr;
  logic [SOF_LEN-1:0] sof_next;
  logic [SYM_N-2:0] sym_sr;
  logic [SYM_N-1:0] sym_next;
  logic [SC_W-1:0]  sym_ctr;
  logic [NB_W-1:0]  nib_ctr;
  logic [7-BPS:0]   byte_sr;
  logic [7:0]       byte_new;
  logic [LEN_W-1:0] byte_ctr;
  logic             sym_ok;
  logic [BPS-1:0]   sym_val;
  logic             f_en_nx, f_end_nx, d_en_nx, err_nx;

  assign fall      = sync[1] & ~sync[0];
  assign busy      = (state != IDLE);
  assign chip_tick = (state != IDLE) && (phase == PH_W'(DEC_PH));
  assign sof_next  = {sof_sr, chip_val};
  assign sym_next  = {sym_sr, chip_val};
  assign byte_new  = {byte_sr, sym_val};

`ifdef PPM_DEC_MAJORITY_EN
  logic s_a, s_b;
  // Capture the two samples preceding the decision phase for the majority vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_a <= 1'b0;
      s_b <= 1'b0;
    end else begin
      if (phase == PH_W'(OSR/2-1)) s_a <= sync[0];
      if (phase == PH_W'(OSR/2))   s_b <= sync[0];
    end
  end
  assign chip_val = (s_a & s_b) | (s_a & sync[0]) | (s_b & sync[0]);
`else
  assign chip_val = sync[0];
`endif

  // A legal symbol is all ones except a single zero at odd chip 2k+1, where chip 0 comes first.
  always_comb begin
    sym_ok  = 1'b0;
    sym_val = '0;
    for (int k = 0; k < M; k++) begin
      if (sym_next == ~(SYM_N'(1) << (SYM_N-2-2*k))) begin
        sym_ok  = 1'b1;
        sym_val = BPS'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and strobe decisions. The EOF check takes priority over the symbol check.
  always_comb begin
    state_nx = state;
    f_en_nx  = 1'b0;
    f_end_nx = 1'b0;
    d_en_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: if (fall) state_nx = HUNT;
      HUNT: if (chip_tick && chip_ctr == CC_W'(SOF_LEN-1)) begin
        if (sof_next == SOF_PAT) begin
          state_nx = DATA;
          f_en_nx  = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      DATA: if (chip_tick) begin
        if (sym_ctr == SC_W'(EOF_LEN-1) && sym_next[EOF_LEN-1:0] == EOF_PAT) begin
          f_end_nx = 1'b1;
          err_nx   = (nib_ctr != '0);
          state_nx = IDLE;
        end else if (sym_ctr == SC_W'(SYM_N-1)) begin
          if (!sym_ok) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end else if (nib_ctr == NB_W'(SPB-1)) begin
            if (byte_ctr == LEN_W'(MAX_BYTES)) begin
              err_nx   = 1'b1;
              state_nx = IDLE;
            end else begin
              d_en_nx = 1'b1;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: synchroniser, phase recovery, chip/symbol/byte shifting, registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      phase     <= '0;
      chip_ctr  <= '0;
      sof_sr    <= '0;
      sym_sr    <= '0;
      sym_ctr   <= '0;
      nib_ctr   <= '0;
      byte_sr   <= '0;
      byte_ctr  <= '0;
      dout      <= '0;
      frame_len <= '0;
      d_en      <= 1'b0;
      f_en      <= 1'b0;
      f_end     <= 1'b0;
      err       <= 1'b0;
    end else begin
      sync  <= {sync[0], din};
      d_en  <= d_en_nx;
      f_en  <= f_en_nx;
      f_end <= f_end_nx;
      err   <= err_nx;

      // An edge at the sample phase is treated as noise and does not move the phase.
      if (state == IDLE || (fall && phase != PH_W'(OSR/2))) phase <= '0;
      else if (phase == PH_W'(OSR-1))                       phase <= '0;
      else                                                  phase <= phase + 1'b1;

      if (state == IDLE) begin
        chip_ctr <= '0;
      end else if (state == HUNT && chip_tick) begin
        sof_sr   <= sof_next[SOF_LEN-2:0];
        chip_ctr <= chip_ctr + 1'b1;
      end

      if (f_en_nx) begin
        sym_ctr  <= '0;
        nib_ctr  <= '0;
        byte_ctr <= '0;
      end else if (state == DATA && chip_tick) begin
        sym_sr <= sym_next[SYM_N-2:0];
        if (sym_ctr == SC_W'(SYM_N-1)) begin
          sym_ctr <= '0;
          byte_sr <= byte_new[7-BPS:0];
          nib_ctr <= (nib_ctr == NB_W'(SPB-1)) ? '0 : nib_ctr + 1'b1;
        end else begin
          sym_ctr <= sym_ctr + 1'b1;
        end
      end

      if (d_en_nx) begin
        dout     <= byte_new;
        byte_ctr <= byte_ctr + 1'b1;
      end
      if (f_end_nx) frame_len <= byte_ctr;
    end
  end
endmodule

// File: tb/tb_lppm_frame_decoder.sv
// Directed bench for lppm_frame_decoder. It uses three instances: the default
// parameters, MAX_BYTES=4, and BPS=4. A negedge monitor counts the strobes and
// captures the decoded bytes.
module tb_lppm_frame_decoder;
  logic clk = 1'b0, rst = 1'b1, line = 1'b1;
  int   sel = 0;
  bit   alt = 1'b0, tog = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      din_v, d_en_v, f_en_v, f_end_v, err_v, busy_v;
  logic [2:0][7:0] dout_v;
  logic [7:0]      flen_a, flen_c;
  logic [2:0]      flen_b;

  for (genvar i = 0; i < 3; i++) begin : g_din
    assign din_v[i] = (sel == i) ? line : 1'b1;
  end

  lppm_frame_decoder u_dut (
    .clk(clk), .rst(rst), .din(din_v[0]), .dout(dout_v[0]), .d_en(d_en_v[0]),
    .f_en(f_en_v[0]), .f_end(f_end_v[0]), .err(err_v[0]), .frame_len(flen_a),
    .busy(busy_v[0]));
  lppm_frame_decoder #(.MAX_BYTES(4)) u_max (
    .clk(clk), .rst(rst), .din(din_v[1]), .dout(dout_v[1]), .d_en(d_en_v[1]),
    .f_en(f_en_v[1]), .f_end(f_end_v[1]), .err(err_v[1]), .frame_len(flen_b),
    .busy(busy_v[1]));
  lppm_frame_decoder #(.BPS(4)) u_b4 (
    .clk(clk), .rst(rst), .din(din_v[2]), .dout(dout_v[2]), .d_en(d_en_v[2]),
    .f_en(f_en_v[2]), .f_end(f_end_v[2]), .err(err_v[2]), .frame_len(flen_c),
    .busy(busy_v[2]));

  int n_den[3], n_fen[3], n_fend[3], n_err[3], n_fe_err[3], n_bad[3];
  int b_den[3], b_fen[3], b_fend[3], b_err[3], b_fe_err[3], b_bad[3];
  logic [7:0] got [3][64];

  // Count strobe cycles per instance and flag illegal strobe overlaps.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (d_en_v[i]) begin
        got[i][n_den[i] % 64] = dout_v[i];
        n_den[i]++;
      end
      if (f_en_v[i])  n_fen[i]++;
      if (f_end_v[i]) n_fend[i]++;
      if (err_v[i])   n_err[i]++;
      if (f_end_v[i] && err_v[i]) n_fe_err[i]++;
      if ((f_en_v[i] && (d_en_v[i] || f_end_v[i] || err_v[i])) ||
          (d_en_v[i] && (f_end_v[i] || err_v[i]))) n_bad[i]++;
    end
  end

  int n_cmp = 0, n_mis = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 3; i++) begin
      b_den[i] = n_den[i];  b_fen[i] = n_fen[i];   b_fend[i] = n_fend[i];
      b_err[i] = n_err[i];  b_fe_err[i] = n_fe_err[i]; b_bad[i] = n_bad[i];
    end
  endtask

  task automatic chk_cnt(input string t, input int i, input int fen, input int den,
                         input int fend, input int er, input int fe_er);
    chk({t, ".f_en"},  n_fen[i]  - b_fen[i],  fen);
    chk({t, ".d_en"},  n_den[i]  - b_den[i],  den);
    chk({t, ".f_end"}, n_fend[i] - b_fend[i], fend);
    chk({t, ".err"},   n_err[i]  - b_err[i],  er);
    chk({t, ".fe_err"}, n_fe_err[i] - b_fe_err[i], fe_er);
    chk({t, ".ovl"},   n_bad[i]  - b_bad[i],  0);
    chk({t, ".busy"},  busy_v[i], 0);
  endtask

  task automatic chk_byte(input string t, input int i, input int j, input logic [7:0] exp);
    chk(t, got[i][(b_den[i] + j) % 64], exp);
  endtask

  task automatic chip(input logic c);
    int per;
    per  = alt ? (tog ? 15 : 17) : 16;
    tog  = !tog;
    line = c;
    repeat (per) @(negedge clk);
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chips8(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) chip(p[i]);
  endtask

  task automatic sof();
    chips8(8'b01111011);
  endtask

  task automatic eof();
    logic [3:0] p;
    p = 4'b1101;
    for (int i = 3; i >= 0; i--) chip(p[i]);
  endtask

  task automatic sym(input int bps, input int v);
    for (int i = 0; i < (2 << bps); i++) chip((i == 2*v+1) ? 1'b0 : 1'b1);
  endtask

  task automatic byte_tx(input int bps, input logic [7:0] b);
    int bi;
    bi = b;
    for (int s = 0; s < 8/bps; s++) sym(bps, (bi >> (8 - bps*(s+1))) & ((1 << bps) - 1));
  endtask

  task automatic frame(input int bps, input int n, input logic [63:0] bytes);
    sof();
    for (int j = 0; j < n; j++) byte_tx(bps, bytes[63-8*j -: 8]);
    eof();
    idle(200);
  endtask

  // A 1-clk low pulse that lands exactly on decoder phase OSR/2 of a 16-clk chip.
  task automatic glitch_one();
    line = 1'b1;
    repeat (9) @(negedge clk);
    line = 1'b0;
    @(negedge clk);
    line = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.dout",  dout_v, 0);
    chk("rst.strb",  {d_en_v, f_en_v, f_end_v, err_v, busy_v}, 0);
    chk("rst.flen",  {flen_a, flen_b, flen_c}, 0);
    rst = 1'b0;
    idle(20);

    // T1: single byte 0x63
    sel = 0; snap();
    frame(2, 1, {8'h63, 56'h0});
    chk_cnt("t1", 0, 1, 1, 1, 0, 0);
    chk_byte("t1.dout", 0, 0, 8'h63);
    chk("t1.flen", flen_a, 1);

    // T2: illegal symbol aborts, frame_len kept, next frame clean
    snap();
    sof(); chips8(8'b10101111); idle(200);
    chk_cnt("t2a", 0, 1, 0, 0, 1, 0);
    chk("t2a.flen", flen_a, 1);
    snap();
    frame(2, 1, {8'hA5, 56'h0});
    chk_cnt("t2b", 0, 1, 1, 1, 0, 0);
    chk_byte("t2b.dout", 0, 0, 8'hA5);

    // T3: EOF after a partial byte -> f_end with err, frame_len 0
    snap();
    sof(); sym(2, 1); sym(2, 2); eof(); idle(200);
    chk_cnt("t3", 0, 1, 0, 1, 1, 1);
    chk("t3.flen", flen_a, 0);

    // T4: 8 bytes, chip period alternating 15/17
    snap(); alt = 1'b1; tog = 1'b0;
    frame(2, 8, 64'h00FF5AC3817E12ED);
    alt = 1'b0;
    chk_cnt("t4", 0, 1, 8, 1, 0, 0);
    chk("t4.flen", flen_a, 8);
    begin
      logic [63:0] exp8;
      exp8 = 64'h00FF5AC3817E12ED;
      for (int j = 0; j < 8; j++) chk($sformatf("t4.b%0d", j), 0 + got[0][(b_den[0]+j)%64], exp8[63-8*j -: 8]);
    end

    // T5a: MAX_BYTES=4 with 5 bytes -> 4 bytes then err, no f_end
    sel = 1; snap();
    frame(2, 5, {40'h1122334455, 24'h0});
    chk_cnt("t5a", 1, 1, 4, 0, 1, 0);
    chk("t5a.flen", flen_b, 0);
    chk_byte("t5a.b0", 1, 0, 8'h11);
    chk_byte("t5a.b3", 1, 3, 8'h44);

    // T5b: BPS=4, byte 0x3C
    sel = 2; snap();
    frame(4, 1, {8'h3C, 56'h0});
    chk_cnt("t5b", 2, 1, 1, 1, 0, 0);
    chk_byte("t5b.dout", 2, 0, 8'h3C);
    chk("t5b.flen", flen_c, 1);

    // T6a: async reset mid-byte, then a clean frame
    sel = 0;
    sof(); sym(2, 1);
    line = 1'b1; repeat (4) @(negedge clk);
    chk("t6.pre_busy", busy_v[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("t6.rst_dout", dout_v[0], 0);
    chk("t6.rst_strb", {d_en_v[0], f_en_v[0], f_end_v[0], err_v[0], busy_v[0]}, 0);
    chk("t6.rst_flen", flen_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(40);
    snap();
    frame(2, 1, {8'h3C, 56'h0});
    chk_cnt("t6a", 0, 1, 1, 1, 0, 0);
    chk_byte("t6a.dout", 0, 0, 8'h3C);

    // T6b: 1-clk zero glitch at the sample phase of a 1 chip in byte 0x1B
    snap();
    sof();
    chip(1'b1); chip(1'b0); chip(1'b1); chip(1'b1);
    glitch_one();
    chip(1'b1); chip(1'b1); chip(1'b1);
    sym(2, 1); sym(2, 2); sym(2, 3);
    eof(); idle(200);
`ifdef PPM_DEC_MAJORITY_EN
    chk_cnt("t6b", 0, 1, 1, 1, 0, 0);
    chk_byte("t6b.dout", 0, 0, 8'h1B);
`else
    chk_cnt("t6b", 0, 1, 0, 0, 1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
